// File: rtl/bkm_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bkm_ctrl                                                  |
// | Purpose  : Iteration sequencer for one bkm_step instance. Latches    |
// |            the operation mode/format on start, walks the iteration   |
// |            index 0..N-1, steers the operand mux, prefetches LUT      |
// |            constants one iteration ahead and strobes result capture. |
// | Ports    : clk, srst (sync, active-high), enable (global freeze),    |
// |            start/abort requests, mode_in/format_in operation select; |
// |            busy/done/start_err status, step_* controls to bkm_step,  |
// |            sel_init operand mux, lut_addr/lut_rd LUT port, cap_en.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module bkm_ctrl #(
    parameter int LOG2N    = 3,
    parameter int N        = 8,
    parameter int STEP_LAT = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             enable,
    input  logic             start,
    input  logic             abort,
    input  logic             mode_in,
    input  logic [1:0]       format_in,
    output logic             busy,
    output logic             done,
    output logic             start_err,
    output logic             step_mode,
    output logic [1:0]       step_format,
    output logic [LOG2N-1:0] step_n,
    output logic             sel_init,
    output logic             step_en,
    output logic [LOG2N-1:0] lut_addr,
    output logic             lut_rd,
    output logic             cap_en
);

    localparam int                c_PH_W    = (STEP_LAT > 1) ? $clog2(STEP_LAT) : 1;
    localparam logic [LOG2N-1:0]  c_N_LAST  = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0]  c_N_ONE   = LOG2N'(1);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(STEP_LAT - 1);
    localparam logic [c_PH_W-1:0] c_PH_ONE  = c_PH_W'(1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_LOAD  = 3'd1;
    localparam logic [2:0] c_S_RUN   = 3'd2;
    localparam logic [2:0] c_S_DRAIN = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [LOG2N-1:0]  r_n;
    logic [c_PH_W-1:0] r_ph;
    logic              r_mode;
    logic [1:0]        r_format;

    logic w_in_run;
    logic w_issue;
    logic w_last;

    assign w_in_run = (r_state == c_S_RUN);
    // Phase 0 of a RUN iteration is the single cycle the step datapath fires.
    assign w_issue  = w_in_run && (r_ph == '0);
    assign w_last   = (r_n == c_N_LAST);

    assign busy        = (r_state != c_S_IDLE);
    assign done        = enable && (r_state == c_S_DONE);
    assign cap_en      = enable && (r_state == c_S_DONE);
    assign start_err   = enable && start && busy;
    assign step_mode   = r_mode;
    assign step_format = r_format;
    assign step_n      = r_n;
    assign sel_init    = (r_state == c_S_LOAD) || (w_in_run && (r_n == '0));
    assign step_en     = enable && w_issue;
    // LOAD fetches entry 0; each issue prefetches the next entry, except the last.
    assign lut_rd      = enable && ((r_state == c_S_LOAD) || (w_issue && !w_last));

    // The address shows the entry being prefetched, parking on N-1 once the
    // table end is reached so it never points past the table.
    always_comb begin
        lut_addr = '0;
        case (r_state)
            c_S_RUN:             lut_addr = w_last ? c_N_LAST : (r_n + c_N_ONE);
            c_S_DRAIN, c_S_DONE: lut_addr = c_N_LAST;
            default:             lut_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state  <= c_S_IDLE;
            r_n      <= '0;
            r_ph     <= '0;
            r_mode   <= 1'b0;
            r_format <= 2'b00;
        end else if (enable) begin
            case (r_state)
                c_S_IDLE: begin
                    if (start && !abort) begin
                        r_mode   <= mode_in;
                        r_format <= format_in;
                        r_n      <= '0;
                        r_ph     <= '0;
                        r_state  <= c_S_LOAD;
                    end
                end
                c_S_LOAD: begin
                    if (abort) begin
                        r_state <= c_S_IDLE;
                        r_n     <= '0;
                        r_ph    <= '0;
                    end else begin
                        r_state <= c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    if (abort) begin
                        r_state <= c_S_IDLE;
                        r_n     <= '0;
                        r_ph    <= '0;
                    end else if (w_last) begin
                        // Last iteration leaves RUN right after its issue cycle;
                        // remaining pipeline latency is covered by DRAIN.
                        if (c_PH_LAST == '0) begin
                            r_state <= c_S_DONE;
                        end else begin
                            r_state <= c_S_DRAIN;
                            r_ph    <= r_ph + c_PH_ONE;
                        end
                    end else if (r_ph == c_PH_LAST) begin
                        r_n  <= r_n + c_N_ONE;
                        r_ph <= '0;
                    end else begin
                        r_ph <= r_ph + c_PH_ONE;
                    end
                end
                c_S_DRAIN: begin
                    if (abort) begin
                        r_state <= c_S_IDLE;
                        r_n     <= '0;
                        r_ph    <= '0;
                    end else if (r_ph == c_PH_LAST) begin
                        r_state <= c_S_DONE;
                        r_ph    <= '0;
                    end else begin
                        r_ph <= r_ph + c_PH_ONE;
                    end
                end
                c_S_DONE: begin
                    // Index is cleared here rather than incremented, so it never wraps.
                    r_state <= c_S_IDLE;
                    r_n     <= '0;
                    r_ph    <= '0;
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_n     <= '0;
                    r_ph    <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bkm_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bkm_ctrl                                               |
// | Purpose  : Self-checking bench for bkm_ctrl. Two instances (step     |
// |            latency 1 and 3) share all inputs; an elapsed-time model  |
// |            predicts every output each cycle, and directed tasks      |
// |            check the documented cycle-exact scenarios.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_bkm_ctrl;

    localparam int c_N = 8;

    logic       clk;
    logic       srst;
    logic       enable;
    logic       start;
    logic       abort;
    logic       mode_in;
    logic [1:0] format_in;

    logic       a_busy, a_done, a_start_err, a_step_mode, a_sel_init, a_step_en, a_lut_rd, a_cap_en;
    logic [1:0] a_step_format;
    logic [2:0] a_step_n, a_lut_addr;
    logic       b_busy, b_done, b_start_err, b_step_mode, b_sel_init, b_step_en, b_lut_rd, b_cap_en;
    logic [1:0] b_step_format;
    logic [2:0] b_step_n, b_lut_addr;

    logic [15:0] a_vec, b_vec, exp_a, exp_b;

    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;

    // Model state: cycles elapsed in the current operation (0 = idle).
    int         t_a = 0, t_b = 0;
    logic       m_a = 1'b0, m_b = 1'b0;
    logic [1:0] f_a = 2'b00, f_b = 2'b00;

    bkm_ctrl #(.LOG2N(3), .N(c_N), .STEP_LAT(1)) dut (
        .clk(clk), .srst(srst), .enable(enable), .start(start), .abort(abort),
        .mode_in(mode_in), .format_in(format_in),
        .busy(a_busy), .done(a_done), .start_err(a_start_err),
        .step_mode(a_step_mode), .step_format(a_step_format), .step_n(a_step_n),
        .sel_init(a_sel_init), .step_en(a_step_en), .lut_addr(a_lut_addr),
        .lut_rd(a_lut_rd), .cap_en(a_cap_en)
    );

    bkm_ctrl #(.LOG2N(3), .N(c_N), .STEP_LAT(3)) dut3 (
        .clk(clk), .srst(srst), .enable(enable), .start(start), .abort(abort),
        .mode_in(mode_in), .format_in(format_in),
        .busy(b_busy), .done(b_done), .start_err(b_start_err),
        .step_mode(b_step_mode), .step_format(b_step_format), .step_n(b_step_n),
        .sel_init(b_sel_init), .step_en(b_step_en), .lut_addr(b_lut_addr),
        .lut_rd(b_lut_rd), .cap_en(b_cap_en)
    );

    assign a_vec = {a_busy, a_done, a_start_err, a_step_mode, a_step_format, a_step_n,
                    a_sel_init, a_step_en, a_lut_addr, a_lut_rd, a_cap_en};
    assign b_vec = {b_busy, b_done, b_start_err, b_step_mode, b_step_format, b_step_n,
                    b_sel_init, b_step_en, b_lut_addr, b_lut_rd, b_cap_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs from the timing rules: LOAD at t=1, iteration n issues
    // at t = 2 + n*lat, done at t = 2 + N*lat.
    function automatic logic [15:0] model_vec(input int t, input int lat, input logic en,
                                              input logic st, input logic md, input logic [1:0] fm);
        int   done_t, n, ph, lut;
        logic run, se, lr, sel, dn, serr, bsy;
        done_t = 2 + c_N * lat;
        run    = (t >= 2) && (t < done_t);
        n      = 0;
        ph     = 0;
        if (run) begin
            n  = (t - 2) / lat;
            ph = (t - 2) % lat;
        end else if (t == done_t) begin
            n = c_N - 1;
        end
        lut  = (t <= 1) ? 0 : ((n + 1 < c_N) ? n + 1 : c_N - 1);
        se   = en && run && (ph == 0);
        lr   = en && ((t == 1) || (run && (ph == 0) && (n < c_N - 1)));
        sel  = (t == 1) || (run && (n == 0));
        dn   = en && (t == done_t);
        serr = en && st && (t != 0);
        bsy  = (t != 0);
        return {bsy, dn, serr, md, fm, 3'(n), sel, se, 3'(lut), lr, dn};
    endfunction

    function automatic int next_t(input int t, input int lat, input logic rs, input logic en,
                                  input logic st, input logic ab);
        if (rs) return 0;
        if (!en) return t;
        if (t == 0) return (st && !ab) ? 1 : 0;
        if (t == 2 + c_N * lat) return 0;
        if (ab) return 0;
        return t + 1;
    endfunction

    always @(posedge clk) begin
        if (srst) begin
            m_a = 1'b0; f_a = 2'b00; m_b = 1'b0; f_b = 2'b00;
        end else if (enable && start && !abort) begin
            if (t_a == 0) begin m_a = mode_in; f_a = format_in; end
            if (t_b == 0) begin m_b = mode_in; f_b = format_in; end
        end
        t_a = next_t(t_a, 1, srst, enable, start, abort);
        t_b = next_t(t_b, 3, srst, enable, start, abort);
    end

    always @(negedge clk) begin
        if (mon_on) begin
            exp_a = model_vec(t_a, 1, enable, start, m_a, f_a);
            exp_b = model_vec(t_b, 3, enable, start, m_b, f_b);
            checks++;
            if (a_vec !== exp_a) begin
                errors++;
                $display("FAIL mon_lat1 @%0t: got %h expected %h", $time, a_vec, exp_a);
            end
            checks++;
            if (b_vec !== exp_b) begin
                errors++;
                $display("FAIL mon_lat3 @%0t: got %h expected %h", $time, b_vec, exp_b);
            end
        end
    end

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        start = 1'b0; abort = 1'b0; srst = 1'b0; enable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_busy === 1'b0 && b_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_idle: busy %b/%b expected 0/0", tag, a_busy, b_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        srst = 1'b1; enable = 1'($urandom); start = 1'($urandom); abort = 1'($urandom);
        mode_in = 1'($urandom); format_in = 2'($urandom);
        @(posedge clk); #1;
        mon_on = 1'b1;
        @(negedge clk);
        checks++;
        if (a_vec !== 16'h0 || b_vec !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h expected 0000/0000", a_vec, b_vec);
        end
        @(posedge clk); #1;
        srst = 1'b0; enable = 1'b1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++;
        if (a_vec !== 16'h0 || b_vec !== 16'h0) begin
            errors++;
            $display("FAIL reset_release: got %h/%h expected 0000/0000", a_vec, b_vec);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        logic [2:0] exp_addr;
        for (int c = 0; c <= 11; c++) begin
            start = (c == 0); mode_in = 1'b1; format_in = 2'b10;
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (!(a_busy === 1'b1 && a_lut_addr === 3'd0 && a_lut_rd === 1'b1 &&
                      a_sel_init === 1'b1 && a_step_en === 1'b0)) begin
                    errors++;
                    $display("FAIL nom_load: got vec %h expected busy,lut_rd,sel_init=1 lut_addr=0", a_vec);
                end
            end
            if (c >= 2 && c <= 9) begin
                exp_addr = (c <= 8) ? 3'(c - 1) : 3'd7;
                checks++;
                if (a_step_en !== 1'b1 || a_step_n !== 3'(c - 2)) begin
                    errors++;
                    $display("FAIL nom_step c%0d: step_en=%b step_n=%0d expected 1/%0d", c, a_step_en, a_step_n, c - 2);
                end
                checks++;
                if (a_sel_init !== 1'(c == 2)) begin
                    errors++;
                    $display("FAIL nom_sel_init c%0d: got %b expected %b", c, a_sel_init, (c == 2));
                end
                checks++;
                if (a_lut_rd !== 1'(c <= 8) || a_lut_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL nom_lut c%0d: rd=%b addr=%0d expected %b/%0d", c, a_lut_rd, a_lut_addr, (c <= 8), exp_addr);
                end
            end
            checks++;
            if (a_done !== 1'(c == 10) || a_cap_en !== 1'(c == 10)) begin
                errors++;
                $display("FAIL nom_done c%0d: done=%b cap_en=%b expected %b", c, a_done, a_cap_en, (c == 10));
            end
            if (c == 10) begin
                checks++;
                if (a_step_mode !== 1'b1 || a_step_format !== 2'b10) begin
                    errors++;
                    $display("FAIL nom_latch: mode=%b fmt=%b expected 1/10", a_step_mode, a_step_format);
                end
            end
            if (c == 11) begin
                checks++;
                if (a_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL nom_busy_end: got %b expected 0", a_busy);
                end
            end
            @(posedge clk); #1;
        end
        wait_idle("nominal");
    endtask

    task automatic test_latency();
        int   pulses;
        int   exp_n;
        logic exp_se;
        pulses = 0;
        for (int c = 0; c <= 28; c++) begin
            start = (c == 0); mode_in = 1'b0; format_in = 2'b01;
            @(negedge clk);
            exp_se = (c >= 2) && (c <= 23) && ((c - 2) % 3 == 0);
            checks++;
            if (b_step_en !== exp_se) begin
                errors++;
                $display("FAIL lat_step_en c%0d: got %b expected %b", c, b_step_en, exp_se);
            end
            checks++;
            if (b_done !== 1'(c == 26)) begin
                errors++;
                $display("FAIL lat_done c%0d: got %b expected %b", c, b_done, (c == 26));
            end
            if (c >= 2 && c <= 25) begin
                exp_n = ((c - 2) / 3 > 7) ? 7 : (c - 2) / 3;
                checks++;
                if (b_step_n !== 3'(exp_n)) begin
                    errors++;
                    $display("FAIL lat_step_n c%0d: got %0d expected %0d", c, b_step_n, exp_n);
                end
            end
            if (c >= 27) begin
                checks++;
                if (b_step_n !== 3'd0 || b_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL lat_after_done c%0d: step_n=%0d busy=%b expected 0/0", c, b_step_n, b_busy);
                end
            end
            if (b_step_en === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 8) begin
            errors++;
            $display("FAIL lat_pulse_count: got %0d expected 8", pulses);
        end
        wait_idle("latency");
    endtask

    task automatic test_enable_stall();
        int se_cnt, rd_cnt, done_cnt, done_c;
        se_cnt = 0; rd_cnt = 0; done_cnt = 0; done_c = -1;
        for (int c = 0; c <= 15; c++) begin
            start = (c == 0); mode_in = 1'($urandom); format_in = 2'($urandom);
            enable = !(c >= 5 && c <= 8);
            @(negedge clk);
            if (c >= 2) begin
                if (a_step_en === 1'b1) se_cnt++;
                if (a_lut_rd === 1'b1) rd_cnt++;
            end
            if (a_done === 1'b1) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            @(posedge clk); #1;
        end
        enable = 1'b1;
        checks++;
        if (done_c != 14 || done_cnt != 1) begin
            errors++;
            $display("FAIL stall_done: first cycle %0d count %0d expected 14/1", done_c, done_cnt);
        end
        checks++;
        if (se_cnt != 8 || rd_cnt != 7) begin
            errors++;
            $display("FAIL stall_pulses: step_en=%0d lut_rd=%0d expected 8/7", se_cnt, rd_cnt);
        end
        wait_idle("stall");
    endtask

    task automatic test_abort();
        for (int c = 0; c <= 10; c++) begin
            start = (c == 0); abort = (c == 6); mode_in = 1'b1; format_in = 2'b01;
            @(negedge clk);
            if (c == 7) begin
                checks++;
                if (a_busy !== 1'b0 || a_step_n !== 3'd0 || a_lut_addr !== 3'd0) begin
                    errors++;
                    $display("FAIL abort_idle: busy=%b step_n=%0d lut_addr=%0d expected 0/0/0", a_busy, a_step_n, a_lut_addr);
                end
                checks++;
                if (a_step_mode !== 1'b1 || a_step_format !== 2'b01) begin
                    errors++;
                    $display("FAIL abort_hold: mode=%b fmt=%b expected 1/01", a_step_mode, a_step_format);
                end
            end
            if (c >= 7) begin
                checks++;
                if (a_done !== 1'b0 || a_cap_en !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_no_done c%0d: done=%b cap_en=%b expected 0/0", c, a_done, a_cap_en);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0 || a_lut_rd !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_idle: busy=%b/%b lut_rd=%b expected 0/0/0", a_busy, b_busy, a_lut_rd);
        end
        @(posedge clk); #1;
        wait_idle("abort");
    endtask

    task automatic test_collision();
        for (int c = 0; c <= 13; c++) begin
            start = (c == 0 || c == 4 || c == 10 || c == 11);
            mode_in = (c == 0) ? 1'b0 : 1'b1;
            format_in = (c == 0) ? 2'b11 : 2'b00;
            @(negedge clk);
            checks++;
            if (a_start_err !== 1'(c == 4 || c == 10)) begin
                errors++;
                $display("FAIL coll_start_err c%0d: got %b expected %b", c, a_start_err, (c == 4 || c == 10));
            end
            checks++;
            if (a_done !== 1'(c == 10)) begin
                errors++;
                $display("FAIL coll_done c%0d: got %b expected %b", c, a_done, (c == 10));
            end
            if (c == 10) begin
                checks++;
                if (a_step_mode !== 1'b0 || a_step_format !== 2'b11) begin
                    errors++;
                    $display("FAIL coll_latch: mode=%b fmt=%b expected 0/11", a_step_mode, a_step_format);
                end
            end
            if (c == 12) begin
                checks++;
                if (a_busy !== 1'b1 || a_lut_rd !== 1'b1 || a_step_mode !== 1'b1 || a_step_format !== 2'b00) begin
                    errors++;
                    $display("FAIL coll_restart: vec %h expected LOAD with mode=1 fmt=00", a_vec);
                end
            end
            @(posedge clk); #1;
        end
        wait_idle("collision");
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 17; c++) begin
            start = (c == 0 || c == 6); srst = (c == 5); enable = (c != 5);
            mode_in = 1'b1; format_in = 2'b11;
            @(negedge clk);
            if (c == 6) begin
                checks++;
                if (a_vec !== 16'h0 || b_vec !== 16'h0) begin
                    errors++;
                    $display("FAIL rstmid_zero: got %h/%h expected 0000/0000", a_vec, b_vec);
                end
            end
            checks++;
            if (a_done !== 1'(c == 16)) begin
                errors++;
                $display("FAIL rstmid_done c%0d: got %b expected %b", c, a_done, (c == 16));
            end
            @(posedge clk); #1;
        end
        wait_idle("rstmid");
    endtask

    task automatic test_random();
        int done_seen;
        done_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            srst      = ($urandom_range(0, 199) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            start     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            mode_in   = 1'($urandom);
            format_in = 2'($urandom);
            @(negedge clk);
            if (a_done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (done_seen == 0) begin
            errors++;
            $display("FAIL random_progress: got %0d completions expected >0", done_seen);
        end
        wait_idle("random");
    endtask

    initial begin
        srst = 1'b1; enable = 1'b0; start = 1'b0; abort = 1'b0;
        mode_in = 1'b0; format_in = 2'b00;
        #1;
        test_reset();
        test_nominal();
        test_latency();
        test_enable_stall();
        test_abort();
        test_collision();
        test_reset_mid();
        test_random();
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
